// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver state encodings and line levels.
// Parity helper is used by uart_tx only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    STATE_IDLE   = 3'd0,
    STATE_START  = 3'd1,
    STATE_DATA   = 3'd2,
    STATE_PARITY = 3'd3,
    STATE_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_STATE_IDLE   = 3'd0,
    RX_STATE_START  = 3'd1,
    RX_STATE_DATA   = 3'd2,
    RX_STATE_PARITY = 3'd3,
    RX_STATE_STOP   = 3'd4
  } rx_state_e;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic calc_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with first-word fall-through read data.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding an MSB-first start/data/stop serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 8,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] byte_out,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       uart_data,
  output logic       busy
);

  localparam int CW = $clog2(CLOCKS_PER_BIT);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          uart_data_q, uart_data_d;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  logic       fifo_push, fifo_pop, fifo_full, fifo_empty, load;
  logic [7:0] fifo_data;
  logic       last_tick;

  assign fifo_push = byte_valid && !fifo_full;
  assign last_tick = (bit_cnt_q == CW'(CLOCKS_PER_BIT - 1));

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (fifo_push),
    .wr_data (byte_out),
    .rd_en   (fifo_pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // The line level is computed from the current state and registered, so the
  // pin lags the state by one cycle and has no path from any input.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    uart_data_d = UART_IDLE_LEVEL;
    fifo_pop    = 1'b0;
    load        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif
    if (state_q != STATE_IDLE) begin
      bit_cnt_d = last_tick ? '0 : bit_cnt_q + CW'(1);
    end
    case (state_q)
      STATE_IDLE: begin
        load = !fifo_empty;
      end
      STATE_START: begin
        uart_data_d = 1'b0;
        if (last_tick) begin
          bit_idx_d = '0;
          state_d   = STATE_DATA;
        end
      end
      STATE_DATA: begin
        uart_data_d = shift_q[7];
        if (last_tick) begin
          shift_d   = {shift_q[6:0], 1'b0};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = STATE_PARITY;
`else
            state_d = STATE_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      STATE_PARITY: begin
        uart_data_d = parity_q;
        if (last_tick) begin
          bit_idx_d = '0;
          state_d   = STATE_STOP;
        end
      end
`endif
      STATE_STOP: begin
        if (last_tick) begin
          if (bit_idx_q == 3'(STOP_BITS - 1)) begin
            bit_idx_d = '0;
            state_d   = STATE_IDLE;
            load      = !fifo_empty;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: state_d = STATE_IDLE;
    endcase
    // Shared by IDLE and the end of STOP so queued frames follow with no gap.
    if (load) begin
      fifo_pop  = 1'b1;
      shift_d   = fifo_data;
      bit_cnt_d = '0;
      state_d   = STATE_START;
`ifdef UART_TX_PARITY_EN
      parity_d  = calc_parity(fifo_data);
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= STATE_IDLE;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      uart_data_q <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      uart_data_q <= uart_data_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign uart_data  = uart_data_q;
  assign byte_ready = !fifo_full;
  assign busy       = (state_q != STATE_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: random and directed bytes decoded by a sampling line receiver.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx;

  localparam int CPB   = 8;
  localparam int STOP  = 1;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME = (9 + P + STOP) * CPB;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       uart_data;
  logic       busy;

  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         mon_frames = 0;
  bit         mon_busy = 1'b0;
  int         hs_cyc;
  logic       mon_samp [FRAME];

  uart_tx #(
    .CLOCKS_PER_BIT (CPB),
    .STOP_BITS      (STOP),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .uart_data  (uart_data),
    .busy       (busy)
  );

  initial forever #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Ideal line level for a frame slot: start, data MSB first, [parity], stop.
  function automatic logic ideal(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[8 - slot];
`ifdef UART_TX_PARITY_EN
    if (slot == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Called just after a negedge; the handshake edge is the following posedge.
  task automatic push(input logic [7:0] b, output bit acc);
    byte_out   = b;
    byte_valid = 1'b1;
    acc        = byte_ready;
    if (acc) begin
      exp_q.push_back(b);
      hs_cyc = cyc + 1;
    end
    @(negedge clock);
    byte_valid = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && !mon_busy && busy === 1'b0) && n < budget) begin
      @(negedge clock);
      #1;
      n++;
    end
    check(tag, 32'(n < budget), 1);
  endtask

  // Line receiver: captures one full frame of per-cycle samples after a falling edge.
  initial begin : monitor
    int k, err;
    bit abort;
    logic [7:0] b, dec;
    forever begin
      @(negedge clock);
      if (reset_n === 1'b1 && uart_data === 1'b0) begin
        mon_busy    = 1'b1;
        k           = cyc;
        abort       = 1'b0;
        mon_samp[0] = uart_data;
        for (int j = 1; j < FRAME; j++) begin
          @(negedge clock);
          if (reset_n !== 1'b1) abort = 1'b1;
          mon_samp[j] = uart_data;
        end
        if (!abort) begin
          start_q.push_back(k);
          mon_frames++;
          check("frame_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            b   = exp_q.pop_front();
            err = 0;
            dec = '0;
            for (int j = 0; j < FRAME; j++)
              if (mon_samp[j] !== ideal(b, j / CPB)) err++;
            for (int s = 1; s <= 8; s++) dec = {dec[6:0], mon_samp[s*CPB + CPB/2]};
            check("start_bit", 32'(mon_samp[CPB/2]), 0);
            check("data_byte", 32'(dec), 32'(b));
`ifdef UART_TX_PARITY_EN
            check("parity_bit", 32'(mon_samp[9*CPB + CPB/2]), 32'(^b));
`endif
            check("stop_bit", 32'(mon_samp[FRAME - CPB/2]), 1);
            check("frame_shape", err, 0);
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit acc;
    int n0, sz, nacc, first_rej, frames_before, tries;
    byte_out   = '0;
    byte_valid = 1'b0;
    reset_n    = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_uart_data", 32'(uart_data), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(byte_ready), 1);
    reset_n = 1'b1;
    @(negedge clock);

    // Single byte: latency, busy window, line back to idle.
    push(8'hA5, acc);
    n0 = hs_cyc;
    check("single_accept", 32'(acc), 1);
    check("busy_queued", 32'(busy), 1);
    wait_until(n0 + FRAME);
    check("busy_stop", 32'(busy), 1);
    wait_until(n0 + 2 + FRAME);
    check("busy_end", 32'(busy), 0);
    check("idle_after", 32'(uart_data), 1);
    wait_drain("single_drain", 4 * FRAME);
    check("latency", start_q[start_q.size()-1] - n0, 2);

    // Back-to-back frames with no idle gap.
    sz = start_q.size();
    push(8'h00, acc); check("b2b_accept0", 32'(acc), 1);
    push(8'hFF, acc); check("b2b_accept1", 32'(acc), 1);
    push(8'h3C, acc); check("b2b_accept2", 32'(acc), 1);
    wait_drain("b2b_drain", 5 * FRAME);
    check("b2b_gap1", start_q[sz+1] - start_q[sz], FRAME);
    check("b2b_gap2", start_q[sz+2] - start_q[sz+1], FRAME);
    check("b2b_total", start_q[sz+2] + FRAME - start_q[sz], 3 * FRAME);

    // Directed patterns (stop-bit and parity boundaries).
    push(8'h81, acc);
    push(8'h07, acc);
    push(8'h03, acc);
    wait_drain("directed_drain", 5 * FRAME);

    // Full FIFO: one pop frees a slot, then back-pressure.
    nacc = 0;
    first_rej = -1;
    for (int i = 0; i < 10; i++) begin
      push(8'($urandom), acc);
      if (acc) nacc++;
      else if (first_rej < 0) first_rej = i;
    end
    check("full_accepted", nacc, DEPTH + 1);
    check("full_first_reject", first_rej, DEPTH + 1);
    check("full_ready_low", 32'(byte_ready), 0);
    wait_drain("full_drain", (DEPTH + 3) * FRAME);

    // Random traffic with random gaps.
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, FRAME + 20)) @(negedge clock);
      tries = 0;
      do begin
        push(8'($urandom), acc);
        tries++;
      end while (!acc && tries < 2 * FRAME);
      check("rand_accept", 32'(acc), 1);
    end
    wait_drain("rand_drain", (DEPTH + 3) * FRAME);

    // Asynchronous reset mid-frame discards the frame and the queued byte.
    push(8'h5A, acc);
    push(8'hC3, acc);
    repeat (30) @(negedge clock);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_uart_data", 32'(uart_data), 1);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_ready", 32'(byte_ready), 1);
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    frames_before = mon_frames;
    repeat (3 * FRAME) @(negedge clock);
    check("no_stale_frame", mon_frames, frames_before);
    check("post_rst_busy", 32'(busy), 0);

    check("all_sent", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
